// File: rtl/vc_host_pkg.sv
// Shared encodings for the videocard host master: command ops, control
// register map and the sequencing FSM states.
package vc_host_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_RAM = 2'd0,
        OP_LOAD_ROM = 2'd1,
        OP_RUN      = 2'd2,
        OP_READBACK = 2'd3
    } op_t;

    localparam logic [2:0] CTL_CORE_EN = 3'd0;
    localparam logic [2:0] CTL_START   = 3'd1;
    localparam logic [2:0] CTL_CLR     = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CFG,
        S_START,
        S_WAIT_IRQ,
        S_CLEAR,
        S_READ,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/vc_rd_latency_pipe.sv
// Valid-bit shift register matching the slave's fixed read latency; the last
// stage marks the cycle in which readdata belongs to an issued read.
module vc_rd_latency_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic shift_in,
    output logic valid_out,
    output logic busy
);

    logic sr_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (srst) sr_reg[0] <= 1'b0;
        else      sr_reg[0] <= shift_in;
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (srst) sr_reg[gi] <= 1'b0;
                else      sr_reg[gi] <= sr_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) busy = busy | sr_reg[i];
    end

    assign valid_out = sr_reg[DEPTH-1];

endmodule

// File: rtl/vc_host_master.sv
// Host-side Avalon-MM master: bulk loads RAM/ROM, runs the cores with an
// interrupt handshake, and streams a RAM window back out.
module vc_host_master import vc_host_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int AW         = 17,
    parameter int WIDTH_CTRL = 8,
    parameter int RD_LATENCY = 2,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_sink_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [AW-2:0]         cmd_base,
    input  logic [15:0]           cmd_len,
    input  logic [3:0]            cmd_core_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [AW-1:0]         avm_address,
    output logic [WIDTH-1:0]      avm_writedata,
    input  logic [WIDTH-1:0]      avm_readdata,
    output logic                  avm_write,
    output logic                  avm_read,
    output logic [3:0]            avm_byteenable,
    output logic [2:0]            ctl_address,
    output logic [WIDTH_CTRL-1:0] ctl_writedata,
    input  logic [WIDTH_CTRL-1:0] ctl_readdata,
    output logic                  ctl_write,
    output logic                  ctl_read,
    input  logic                  irq,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                  state_reg, state_next;
    op_t                     op_reg, op_next;
    logic [AW-2:0]           addr_reg, addr_next;
    logic [15:0]             rem_reg, rem_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    avm_write_reg, avm_write_next;
    logic                    avm_read_reg, avm_read_next;
    logic [AW-1:0]           avm_address_reg, avm_address_next;
    logic [WIDTH-1:0]        avm_writedata_reg, avm_writedata_next;
    logic                    ctl_write_reg, ctl_write_next;
    logic [2:0]              ctl_address_reg, ctl_address_next;
    logic [WIDTH_CTRL-1:0]   ctl_writedata_reg, ctl_writedata_next;
    logic                    done_reg, done_next;
    logic                    timeout_err_reg, timeout_err_next;
    logic                    pipe_valid, pipe_busy;
    logic                    unused_ctl;

    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            state_reg         <= S_IDLE;
            op_reg            <= OP_LOAD_RAM;
            addr_reg          <= '0;
            rem_reg           <= '0;
            cnt_reg           <= '0;
            avm_write_reg     <= 1'b0;
            avm_read_reg      <= 1'b0;
            avm_address_reg   <= '0;
            avm_writedata_reg <= '0;
            ctl_write_reg     <= 1'b0;
            ctl_address_reg   <= '0;
            ctl_writedata_reg <= '0;
            done_reg          <= 1'b0;
            timeout_err_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            op_reg            <= op_next;
            addr_reg          <= addr_next;
            rem_reg           <= rem_next;
            cnt_reg           <= cnt_next;
            avm_write_reg     <= avm_write_next;
            avm_read_reg      <= avm_read_next;
            avm_address_reg   <= avm_address_next;
            avm_writedata_reg <= avm_writedata_next;
            ctl_write_reg     <= ctl_write_next;
            ctl_address_reg   <= ctl_address_next;
            ctl_writedata_reg <= ctl_writedata_next;
            done_reg          <= done_next;
            timeout_err_reg   <= timeout_err_next;
        end
    end

    // Bus strobes are computed from the next state so every strobe is
    // visible during the state that owns it, never in IDLE.
    always_comb begin
        state_next         = state_reg;
        op_next            = op_reg;
        addr_next          = addr_reg;
        rem_next           = rem_reg;
        cnt_next           = cnt_reg;
        avm_write_next     = 1'b0;
        avm_read_next      = 1'b0;
        avm_address_next   = avm_address_reg;
        avm_writedata_next = avm_writedata_reg;
        ctl_write_next     = 1'b0;
        ctl_address_next   = ctl_address_reg;
        ctl_writedata_next = ctl_writedata_reg;
        done_next          = 1'b0;
        timeout_err_next   = timeout_err_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_next          = op_t'(cmd_op);
                    addr_next        = cmd_base;
                    rem_next         = cmd_len;
                    timeout_err_next = 1'b0;
                    case (op_t'(cmd_op))
                        OP_RUN: begin
                            state_next         = S_CFG;
                            ctl_write_next     = 1'b1;
                            ctl_address_next   = CTL_CORE_EN;
                            ctl_writedata_next = WIDTH_CTRL'(cmd_core_en);
                        end
                        OP_READBACK: begin
                            if (cmd_len == 16'd0) done_next  = 1'b1;
                            else                  state_next = S_READ;
                        end
                        default: begin
                            if (cmd_len == 16'd0) done_next  = 1'b1;
                            else                  state_next = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                // rem_reg==0 is the cycle holding the final write strobe.
                if (rem_reg == 16'd0) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else if (wr_valid) begin
                    avm_write_next     = 1'b1;
                    avm_address_next   = {op_reg == OP_LOAD_ROM, addr_reg};
                    avm_writedata_next = wr_data;
                    addr_next          = addr_reg + (AW-1)'(1);
                    rem_next           = rem_reg - 16'd1;
                end
            end
            S_CFG: begin
                state_next         = S_START;
                ctl_write_next     = 1'b1;
                ctl_address_next   = CTL_START;
                ctl_writedata_next = WIDTH_CTRL'(1);
            end
            S_START: begin
                state_next = S_WAIT_IRQ;
                cnt_next   = '0;
            end
            S_WAIT_IRQ: begin
                if (irq || cnt_reg == CW'(TIMEOUT - 1)) begin
                    state_next         = S_CLEAR;
                    ctl_write_next     = 1'b1;
                    ctl_address_next   = CTL_CLR;
                    ctl_writedata_next = WIDTH_CTRL'(1);
                    timeout_err_next   = ~irq;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_CLEAR: begin
                state_next = S_IDLE;
                done_next  = 1'b1;
            end
            S_READ: begin
                avm_read_next    = 1'b1;
                avm_address_next = {1'b0, addr_reg};
                addr_next        = addr_reg + (AW-1)'(1);
                rem_next         = rem_reg - 16'd1;
                if (rem_reg == 16'd1) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pipe_busy && !avm_read_reg) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    vc_rd_latency_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .srst     (reset_sink_reset),
        .shift_in (avm_read_reg),
        .valid_out(pipe_valid),
        .busy     (pipe_busy)
    );

    assign cmd_ready      = (state_reg == S_IDLE);
    assign busy           = (state_reg != S_IDLE);
    assign wr_ready       = (state_reg == S_WRITE) && (rem_reg != 16'd0);
    assign rd_valid       = pipe_valid;
    assign rd_data        = avm_readdata;
    assign avm_address    = avm_address_reg;
    assign avm_writedata  = avm_writedata_reg;
    assign avm_write      = avm_write_reg;
    assign avm_read       = avm_read_reg;
    assign avm_byteenable = 4'hF;
    assign ctl_address    = ctl_address_reg;
    assign ctl_writedata  = ctl_writedata_reg;
    assign ctl_write      = ctl_write_reg;
    assign ctl_read       = 1'b0;
    assign done           = done_reg;
    assign timeout_err    = timeout_err_reg;
    assign unused_ctl     = ^ctl_readdata;

endmodule

// File: tb/tb_vc_host_master.sv
// Bench for vc_host_master: directed command table, randomized commands
// against a transaction-level model, and a reset-abort sequence.
module tb_vc_host_master;

    localparam int WIDTH = 32;
    localparam int AW    = 17;
    localparam int WC    = 8;
    localparam int RL    = 2;
    localparam int TO    = 100;
    localparam logic [1:0] LR = 2'd0, LM = 2'd1, RN = 2'd2, RB = 2'd3;

    logic clk = 1'b0;
    logic srst;
    logic cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [AW-2:0] cmd_base;
    logic [15:0] cmd_len;
    logic [3:0] cmd_core_en;
    logic [WIDTH-1:0] wr_data, rd_data;
    logic wr_valid, wr_ready, rd_valid;
    logic [AW-1:0] avm_address;
    logic [WIDTH-1:0] avm_writedata, avm_readdata;
    logic avm_write, avm_read;
    logic [3:0] avm_byteenable;
    logic [2:0] ctl_address;
    logic [WC-1:0] ctl_writedata, ctl_readdata;
    logic ctl_write, ctl_read, irq, busy, done, timeout_err;

    vc_host_master #(.WIDTH(WIDTH), .AW(AW), .WIDTH_CTRL(WC), .RD_LATENCY(RL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_sink_reset(srst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_base(cmd_base),
        .cmd_len(cmd_len), .cmd_core_en(cmd_core_en),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_write(avm_write), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .ctl_address(ctl_address), .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata),
        .ctl_write(ctl_write), .ctl_read(ctl_read),
        .irq(irq), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    assign ctl_readdata = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave read data is a fixed function of the address.
    function automatic logic [WIDTH-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    logic s1_v;
    logic [AW-1:0] s1_addr;
    always @(posedge clk) begin
        s1_v    <= avm_read;
        s1_addr <= avm_address;
        avm_readdata <= s1_v ? mem_word(s1_addr) : 32'hDEAD_BEEF;
    end

    // Bus monitor
    logic [AW-1:0] wa_q[$], ra_q[$];
    logic [WIDTH-1:0] wd_q[$], vd_q[$];
    logic [2:0] ca_q[$];
    logic [WC-1:0] cd_q[$];
    int wc_q[$], rc_q[$], vc_q[$], cc_q[$];
    int done_cnt = 0, done_cyc = 0, proto_err = 0, start_cyc = -1000, irq_delay = -1;

    always @(negedge clk) begin
        if (!srst) begin
            if (avm_write) begin wa_q.push_back(avm_address); wd_q.push_back(avm_writedata); wc_q.push_back(cyc); end
            if (avm_read) begin ra_q.push_back(avm_address); rc_q.push_back(cyc); end
            if (rd_valid) begin vd_q.push_back(rd_data); vc_q.push_back(cyc); end
            if (ctl_write) begin
                ca_q.push_back(ctl_address); cd_q.push_back(ctl_writedata); cc_q.push_back(cyc);
                if (ctl_address == 3'd1) start_cyc = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if ((avm_read && avm_write) || (!busy && (avm_read || avm_write || ctl_write)) ||
                ctl_read || avm_byteenable != 4'hF)
                proto_err++;
        end
    end

    // Videocard interrupt: rises irq_delay cycles after the START write, drops on clear.
    always @(posedge clk) begin
        if (srst || irq_delay <= 0) irq <= 1'b0;
        else if (ctl_write && ctl_address == 3'd3) irq <= 1'b0;
        else if (start_cyc >= 0 && cyc == start_cyc + irq_delay - 1) irq <= 1'b1;
    end

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); rc_q.delete();
        vd_q.delete(); vc_q.delete(); ca_q.delete(); cd_q.delete(); cc_q.delete();
        done_cnt = 0; proto_err = 0; start_cyc = -1000;
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [15:0] base,
                           input logic [15:0] len, input logic [3:0] mask, input int d,
                           input int gap_mode, input logic [AW-1:0] exp_first,
                           input logic [AW-1:0] exp_last, input logic exp_terr);
        logic [WIDTH-1:0] words[$];
        logic [AW-1:0] ea;
        int sent, guard, gaps, acc_cyc, exp_clr, n;
        bit is_load;
        is_load = (op == LR || op == LM);
        n = int'(len);
        for (int i = 0; i < n; i++) words.push_back($urandom);
        clear_mon();
        irq_delay = (op == RN) ? d : -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len; cmd_core_en = mask;
        #1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin @(negedge clk); #1; guard++; end
        acc_cyc = cyc;
        check({tag, " accept_ready"}, cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_base = 16'($urandom); cmd_len = 16'($urandom);
        check({tag, " terr_after_accept"}, timeout_err, 1'b0);
        sent = 0; guard = 0; gaps = 0;
        while (is_load && sent < n && guard < 1000) begin
            if (gap_mode == 1 && sent == 2 && gaps < 2) begin wr_valid = 1'b0; gaps++; end
            else if (gap_mode == 2) wr_valid = ($urandom_range(0, 2) != 0);
            else wr_valid = 1'b1;
            wr_data = words[sent];
            #1;
            if (wr_valid && wr_ready) sent++;
            @(negedge clk);
            guard++;
        end
        wr_valid = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < TO + 300) begin @(negedge clk); guard++; end
        repeat (4) @(negedge clk);
        irq_delay = -1;

        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " busy_after"}, busy, 1'b0);
        check({tag, " protocol"}, proto_err, 0);
        check({tag, " timeout_err"}, timeout_err, exp_terr);
        if (op == RN) begin
            check({tag, " data_port_idle"}, wa_q.size() + ra_q.size(), 0);
            check({tag, " ctl_writes"}, ca_q.size(), 3);
            if (ca_q.size() == 3) begin
                check({tag, " cfg"}, {ca_q[0], cd_q[0]}, {3'd0, 4'h0, mask});
                check({tag, " start"}, {ca_q[1], cd_q[1]}, {3'd1, 8'h01});
                check({tag, " clear"}, {ca_q[2], cd_q[2]}, {3'd3, 8'h01});
                check({tag, " start_cycle"}, cc_q[1], cc_q[0] + 1);
                exp_clr = (d > 0 && d <= TO) ? cc_q[1] + d + 1 : cc_q[1] + TO + 1;
                check({tag, " clear_cycle"}, cc_q[2], exp_clr);
                check({tag, " done_cycle"}, done_cyc, cc_q[2] + 1);
            end
        end else if (n == 0) begin
            check({tag, " no_bus"}, wa_q.size() + ra_q.size() + ca_q.size(), 0);
            check({tag, " done_cycle"}, done_cyc, acc_cyc + 1);
        end else if (is_load) begin
            check({tag, " ctl_idle"}, ca_q.size(), 0);
            check({tag, " write_count"}, wa_q.size(), n);
            if (wa_q.size() == n) begin
                for (int i = 0; i < n; i++) begin
                    ea = {op == LM, 16'(base + 16'(i))};
                    check($sformatf("%s wr_addr[%0d]", tag, i), wa_q[i], ea);
                    check($sformatf("%s wr_data[%0d]", tag, i), wd_q[i], words[i]);
                end
                check({tag, " first_addr"}, wa_q[0], exp_first);
                check({tag, " last_addr"}, wa_q[n-1], exp_last);
                check({tag, " done_cycle"}, done_cyc, wc_q[n-1] + 1);
            end
        end else begin
            check({tag, " no_writes"}, wa_q.size() + ca_q.size(), 0);
            check({tag, " read_count"}, ra_q.size(), n);
            check({tag, " rdvalid_count"}, vd_q.size(), n);
            if (ra_q.size() == n && vd_q.size() == n) begin
                for (int i = 0; i < n; i++) begin
                    ea = {1'b0, 16'(base + 16'(i))};
                    check($sformatf("%s rd_addr[%0d]", tag, i), ra_q[i], ea);
                    check($sformatf("%s rd_data[%0d]", tag, i), vd_q[i], mem_word(ea));
                    check($sformatf("%s rd_cycle[%0d]", tag, i), vc_q[i], rc_q[0] + RL + i);
                end
                check({tag, " first_addr"}, ra_q[0], exp_first);
                check({tag, " last_addr"}, ra_q[n-1], exp_last);
                check({tag, " done_after_data"}, done_cyc > vc_q[n-1], 1'b1);
            end
        end
        $display("cmd %s op=%0d base=%h len=%0d mask=%h irq_delay=%0d done=%0d terr=%0b",
                 tag, op, base, len, mask, d, done_cnt, timeout_err);
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  op;
        logic [15:0] base;
        logic [15:0] len;
        logic [3:0]  mask;
        int          d;
        int          gap_mode;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
        logic        exp_terr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [1:0] op;
        logic [15:0] base, len;
        int d;
        logic [AW-1:0] ef, el;

        vecs[0] = '{"load_ram", LR, 16'h0010, 16'd4, 4'h0, -1, 1, 17'h00010, 17'h00013, 1'b0};
        vecs[1] = '{"load_rom_wrap", LM, 16'hFFFF, 16'd2, 4'h0, -1, 0, 17'h1FFFF, 17'h10000, 1'b0};
        vecs[2] = '{"run_irq", RN, 16'h0000, 16'd0, 4'b0101, 50, 0, 17'h0, 17'h0, 1'b0};
        vecs[3] = '{"run_timeout", RN, 16'h0000, 16'd7, 4'b1010, -1, 0, 17'h0, 17'h0, 1'b1};
        vecs[4] = '{"load_len0", LR, 16'h1234, 16'd0, 4'h0, -1, 0, 17'h0, 17'h0, 1'b0};
        vecs[5] = '{"readback", RB, 16'h0020, 16'd3, 4'h0, -1, 0, 17'h00020, 17'h00022, 1'b0};
        vecs[6] = '{"run_irq_early", RN, 16'h0000, 16'd0, 4'b1111, 1, 0, 17'h0, 17'h0, 1'b0};

        srst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_base = '0; cmd_len = '0;
        cmd_core_en = '0; wr_data = '0; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cmd_ready", cmd_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset strobes", {avm_write, avm_read, ctl_write, ctl_read}, 4'b0);
        check("reset done_terr_rdv", {done, timeout_err, rd_valid}, 3'b0);
        check("reset avm_address", avm_address, 17'h0);
        check("reset avm_writedata", avm_writedata, 32'h0);
        check("reset ctl_addr_data", {ctl_address, ctl_writedata}, 11'h0);
        check("reset byteenable", avm_byteenable, 4'hF);
        srst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_cmd(vecs[i].tag, vecs[i].op, vecs[i].base, vecs[i].len, vecs[i].mask, vecs[i].d,
                    vecs[i].gap_mode, vecs[i].exp_first, vecs[i].exp_last, vecs[i].exp_terr);

        for (int k = 0; k < 14; k++) begin
            op   = 2'($urandom_range(0, 3));
            base = 16'($urandom);
            len  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
            d    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, TO + 10));
            ef   = {op == LM, base};
            el   = {op == LM, 16'(base + len - 16'd1)};
            run_cmd($sformatf("rand%0d", k), op, base, len, 4'($urandom), d, 2, ef, el,
                    op == RN && !(d > 0 && d <= TO));
        end

        // Reset in the middle of a 5-word load after two words.
        clear_mon();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = LR; cmd_base = 16'h0100; cmd_len = 16'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h1111_0000;
        @(negedge clk);
        wr_data = 32'h1111_0001;
        @(negedge clk);
        wr_valid = 1'b0;
        #2 srst = 1'b1;
        @(negedge clk);
        check("abort strobes", {avm_write, avm_read, ctl_write}, 3'b0);
        check("abort cmd_ready", cmd_ready, 1'b1);
        srst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort done_count", done_cnt, 0);
        check("abort write_count", wa_q.size(), 2);
        check("abort busy", busy, 1'b0);
        check("abort protocol", proto_err, 0);
        $display("cmd abort_load writes=%0d done=%0d", wa_q.size(), done_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
